// File: rtl/video_dnn_class_vote.sv
// Per-pixel class vote: popcount per class, argmax, and a min-count reject.
// A per-frame histogram of winning classes is scanned to report the frame majority class.

module class_popcount #(
    parameter int CHANNEL_WIDTH = 7,
    parameter int TCOUNT_WIDTH  = 4
) (
    input  logic [CHANNEL_WIDTH-1:0] vec,
    output logic [TCOUNT_WIDTH-1:0]  cnt
);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < CHANNEL_WIDTH; i++)
            cnt = cnt + TCOUNT_WIDTH'(vec[i]);
    end
endmodule

module video_dnn_class_vote #(
    parameter int NUM_CLASS     = 10,
    parameter int CHANNEL_WIDTH = 7,
    parameter int TUSER_WIDTH   = 1,
    parameter int TNUMBER_WIDTH = 4,
    parameter int TCOUNT_WIDTH  = 4,
    parameter int HIST_WIDTH    = 20,
    parameter int TDATA_WIDTH   = NUM_CLASS*CHANNEL_WIDTH
) (
    input  logic                     aresetn,
    input  logic                     aclk,
    input  logic [TCOUNT_WIDTH-1:0]  param_min_count,
    input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
    input  logic                     s_axi4s_tlast,
    input  logic [TDATA_WIDTH-1:0]   s_axi4s_tdata,
    input  logic                     s_axi4s_tvalid,
    output logic                     s_axi4s_tready,
    output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
    output logic                     m_axi4s_tlast,
    output logic [TNUMBER_WIDTH-1:0] m_axi4s_tnumber,
    output logic [TCOUNT_WIDTH-1:0]  m_axi4s_tcount,
    output logic [TDATA_WIDTH-1:0]   m_axi4s_tdata,
    output logic                     m_axi4s_tvalid,
    input  logic                     m_axi4s_tready,
    output logic                     frame_valid,
    output logic [TNUMBER_WIDTH-1:0] frame_number,
    output logic [HIST_WIDTH-1:0]    frame_count
);
    localparam int STAGES = 3;
    localparam logic [TNUMBER_WIDTH-1:0] REJECT = TNUMBER_WIDTH'(NUM_CLASS);
    localparam logic [TNUMBER_WIDTH-1:0] LAST_IDX = TNUMBER_WIDTH'(NUM_CLASS-1);

    typedef struct packed {
        logic [TUSER_WIDTH-1:0] user;
        logic                   last;
        logic [TDATA_WIDTH-1:0] data;
    } beat_t;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    // Assert asynchronously, release on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_n;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic cke;
    assign cke            = !m_axi4s_tvalid || m_axi4s_tready;
    assign s_axi4s_tready = cke;

    logic [NUM_CLASS-1:0][TCOUNT_WIDTH-1:0] pc;
    for (genvar g = 0; g < NUM_CLASS; g++) begin : g_pc
        class_popcount #(.CHANNEL_WIDTH(CHANNEL_WIDTH), .TCOUNT_WIDTH(TCOUNT_WIDTH)) u_pc (
            .vec(s_axi4s_tdata[g*CHANNEL_WIDTH +: CHANNEL_WIDTH]),
            .cnt(pc[g])
        );
    end

    logic [STAGES:1]                        vld_pipe;
    beat_t                                  s1_beat, s2_beat;
    logic [NUM_CLASS-1:0][TCOUNT_WIDTH-1:0] s1_cnt;
    logic [TNUMBER_WIDTH-1:0]               s2_num, am_num;
    logic [TCOUNT_WIDTH-1:0]                s2_cnt, am_cnt;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        am_num = '0;
        am_cnt = s1_cnt[0];
        for (int c = 1; c < NUM_CLASS; c++) begin
            if (s1_cnt[c] > am_cnt) begin
                am_num = TNUMBER_WIDTH'(c);
                am_cnt = s1_cnt[c];
            end
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe        <= '0;
            s1_beat         <= '0;
            s1_cnt          <= '0;
            s2_beat         <= '0;
            s2_num          <= '0;
            s2_cnt          <= '0;
            m_axi4s_tuser   <= '0;
            m_axi4s_tlast   <= 1'b0;
            m_axi4s_tdata   <= '0;
            m_axi4s_tnumber <= '0;
            m_axi4s_tcount  <= '0;
        end else if (cke) begin
            vld_pipe        <= {vld_pipe[STAGES-1:1], s_axi4s_tvalid};
            s1_beat         <= '{user: s_axi4s_tuser, last: s_axi4s_tlast, data: s_axi4s_tdata};
            s1_cnt          <= pc;
            s2_beat         <= s1_beat;
            s2_num          <= am_num;
            s2_cnt          <= am_cnt;
            m_axi4s_tuser   <= s2_beat.user;
            m_axi4s_tlast   <= s2_beat.last;
            m_axi4s_tdata   <= s2_beat.data;
            m_axi4s_tnumber <= (s2_cnt < param_min_count) ? REJECT : s2_num;
            m_axi4s_tcount  <= s2_cnt;
        end
    end
    assign m_axi4s_tvalid = vld_pipe[STAGES];

    logic hs, fs, acc;
    assign hs  = m_axi4s_tvalid && m_axi4s_tready;
    assign fs  = hs && m_axi4s_tuser[0];
    assign acc = hs && (m_axi4s_tnumber != REJECT);

    logic [NUM_CLASS-1:0][HIST_WIDTH-1:0] hist, shadow;

    // The frame-start beat belongs to the new frame, so it is counted after the clear.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            hist   <= '0;
            shadow <= '0;
        end else if (fs) begin
            shadow <= hist;
            for (int k = 0; k < NUM_CLASS; k++)
                hist[k] <= (acc && m_axi4s_tnumber == TNUMBER_WIDTH'(k)) ? HIST_WIDTH'(1) : '0;
        end else if (acc && hist[m_axi4s_tnumber] != '1) begin
            hist[m_axi4s_tnumber] <= hist[m_axi4s_tnumber] + HIST_WIDTH'(1);
        end
    end

    state_t                   state;
    logic [TNUMBER_WIDTH-1:0] idx, best;
    logic [HIST_WIDTH-1:0]    bestcnt;

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            best         <= '0;
            bestcnt      <= '0;
            frame_valid  <= 1'b0;
            frame_number <= '0;
            frame_count  <= '0;
        end else begin
            frame_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (shadow[idx] > bestcnt) begin
                        best    <= idx;
                        bestcnt <= shadow[idx];
                    end
                    if (idx == LAST_IDX) state <= DONE;
                    else                 idx   <= idx + TNUMBER_WIDTH'(1);
                end
                DONE: begin
                    frame_valid  <= 1'b1;
                    frame_number <= best;
                    frame_count  <= bestcnt;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A new frame start always restarts the scan; class 0 is preloaded.
            if (fs) begin
                state   <= SCAN;
                idx     <= TNUMBER_WIDTH'(1);
                best    <= '0;
                bestcnt <= hist[0];
            end
        end
    end
endmodule

// File: tb/tb_video_dnn_class_vote.sv
// Bench for video_dnn_class_vote: directed beats, queue-based pixel model and frame vote model.

module tb_video_dnn_class_vote;
    localparam int NC  = 10;
    localparam int CW  = 7;
    localparam int TDW = NC*CW;

    logic           aclk = 1'b0;
    logic           aresetn = 1'b0;
    logic [3:0]     param_min_count = '0;
    logic [0:0]     s_tuser = '0;
    logic           s_tlast = 1'b0;
    logic [TDW-1:0] s_tdata = '0;
    logic           s_tvalid = 1'b0;
    logic           s_tready, s_tready2;
    logic           m_tready = 1'b1;
    logic [0:0]     m_tuser, m_tuser2;
    logic           m_tlast, m_tlast2;
    logic [3:0]     m_tnumber, m_tnumber2;
    logic [3:0]     m_tcount, m_tcount2;
    logic [TDW-1:0] m_tdata, m_tdata2;
    logic           m_tvalid, m_tvalid2;
    logic           frame_valid, frame_valid2;
    logic [3:0]     frame_number, frame_number2;
    logic [19:0]    frame_count;
    logic [3:0]     frame_count2;

    always #5 aclk = ~aclk;

    video_dnn_class_vote dut (
        .aresetn(aresetn), .aclk(aclk), .param_min_count(param_min_count),
        .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tdata(s_tdata),
        .s_axi4s_tvalid(s_tvalid), .s_axi4s_tready(s_tready),
        .m_axi4s_tuser(m_tuser), .m_axi4s_tlast(m_tlast), .m_axi4s_tnumber(m_tnumber),
        .m_axi4s_tcount(m_tcount), .m_axi4s_tdata(m_tdata), .m_axi4s_tvalid(m_tvalid),
        .m_axi4s_tready(m_tready), .frame_valid(frame_valid),
        .frame_number(frame_number), .frame_count(frame_count)
    );

    video_dnn_class_vote #(.HIST_WIDTH(4)) dut4 (
        .aresetn(aresetn), .aclk(aclk), .param_min_count(param_min_count),
        .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tdata(s_tdata),
        .s_axi4s_tvalid(s_tvalid), .s_axi4s_tready(s_tready2),
        .m_axi4s_tuser(m_tuser2), .m_axi4s_tlast(m_tlast2), .m_axi4s_tnumber(m_tnumber2),
        .m_axi4s_tcount(m_tcount2), .m_axi4s_tdata(m_tdata2), .m_axi4s_tvalid(m_tvalid2),
        .m_axi4s_tready(m_tready), .frame_valid(frame_valid2),
        .frame_number(frame_number2), .frame_count(frame_count2)
    );

    int errs = 0, checks = 0, cyc = 0, fv_pulses = 0;
    bit run = 0, bp_on = 0;

    always @(posedge aclk) cyc++;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct { logic u; logic l; logic [TDW-1:0] d; int num; int cnt; } pix_t;
    typedef struct { int due; int n1; int c1; int n4; int c4; } fr_t;
    pix_t pq[$];
    fr_t  fq[$];
    int   h1[NC], h4[NC];
    int   last_n1 = 0, last_c1 = 0, last_n4 = 0, last_c4 = 0;

    function automatic void winner(input logic [TDW-1:0] d, output int n, output int c);
        n = 0;
        c = $countones(d[CW-1:0]);
        for (int k = 1; k < NC; k++)
            if ($countones(d[k*CW +: CW]) > c) begin
                n = k;
                c = $countones(d[k*CW +: CW]);
            end
    endfunction

    function automatic void hmax(input int h[NC], output int n, output int c);
        n = 0;
        c = h[0];
        for (int k = 1; k < NC; k++)
            if (h[k] > c) begin
                n = k;
                c = h[k];
            end
    endfunction

    task automatic hist_update(input logic u, input int en);
        fr_t f;
        if (u) begin
            hmax(h1, f.n1, f.c1);
            hmax(h4, f.n4, f.c4);
            f.due = cyc + 11;
            // a scan not yet in its final (DONE) cycle is abandoned
            while (fq.size() > 0 && cyc < fq[fq.size()-1].due - 1) void'(fq.pop_back());
            fq.push_back(f);
            for (int k = 0; k < NC; k++) begin
                h1[k] = 0;
                h4[k] = 0;
            end
        end
        if (en != NC) begin
            if (h1[en] < (1 << 20) - 1) h1[en]++;
            if (h4[en] < 15) h4[en]++;
        end
    endtask

    always @(negedge aclk) begin
        if (run) begin
            bit   exp_fv;
            pix_t p;
            int   en;
            exp_fv = (fq.size() > 0) && (fq[0].due == cyc);
            chk("frame_valid", frame_valid, exp_fv);
            chk("frame_valid_h4", frame_valid2, exp_fv);
            if (frame_valid) fv_pulses++;
            if (exp_fv) begin
                last_n1 = fq[0].n1; last_c1 = fq[0].c1;
                last_n4 = fq[0].n4; last_c4 = fq[0].c4;
                void'(fq.pop_front());
            end
            chk("frame_number", frame_number, last_n1);
            chk("frame_count", frame_count, last_c1);
            chk("frame_number_h4", frame_number2, last_n4);
            chk("frame_count_h4", frame_count2, last_c4);
            if (m_tvalid) begin
                if (pq.size() == 0) chk("spurious_beat", 1, 0);
                else begin
                    p  = pq[0];
                    en = (p.cnt < int'(param_min_count)) ? NC : p.num;
                    chk("tuser", m_tuser, p.u);
                    chk("tlast", m_tlast, p.l);
                    chk("tdata", m_tdata, p.d);
                    chk("tnumber", m_tnumber, en);
                    chk("tcount", m_tcount, p.cnt);
                    chk("tnumber_h4", m_tnumber2, en);
                    if (m_tready) begin
                        void'(pq.pop_front());
                        hist_update(p.u, en);
                    end
                end
            end
            if (s_tvalid && s_tready) begin
                p.u = s_tuser[0]; p.l = s_tlast; p.d = s_tdata;
                winner(s_tdata, p.num, p.cnt);
                pq.push_back(p);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [TDW-1:0] mk(input int ca, input int na, input int cb, input int nb);
        logic [TDW-1:0] d;
        logic [CW-1:0]  va, vb;
        va = CW'((1 << na) - 1);
        vb = CW'((1 << nb) - 1);
        d = '0;
        d[ca*CW +: CW] = va;
        if (nb > 0) d[cb*CW +: CW] = vb;
        return d;
    endfunction

    task automatic send(input logic [TDW-1:0] d, input logic u, input logic l);
        bit ok = 0;
        s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge aclk);
            ok = s_tready;
            @(posedge aclk);
            #1;
        end
        if (!ok) chk("send_timeout", 0, 1);
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic wait_out(input string nm, input int en, input int ec);
        bit seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge aclk);
            seen = m_tvalid;
        end
        chk({nm, "_seen"}, seen, 1);
        chk({nm, "_tnumber"}, m_tnumber, en);
        chk({nm, "_tcount"}, m_tcount, ec);
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_fv(input string nm, input int en, input int ec, input int en4, input int ec4);
        bit seen = 0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge aclk);
            seen = frame_valid;
        end
        chk({nm, "_seen"}, seen, 1);
        chk({nm, "_number"}, frame_number, en);
        chk({nm, "_count"}, frame_count, ec);
        chk({nm, "_number_h4"}, frame_number2, en4);
        chk({nm, "_count_h4"}, frame_count2, ec4);
        @(posedge aclk);
        #1;
    endtask

    // Measures frame-start output handshake to frame_valid, then checks the result.
    task automatic wait_frame(input string nm, input int en, input int ec, input int en4, input int ec4);
        int n = -1;
        for (int t = 0; t < 300 && n < 0; t++) begin
            @(negedge aclk);
            if (m_tvalid && m_tready && m_tuser[0]) n = cyc;
        end
        chk({nm, "_start_seen"}, n >= 0, 1);
        for (int t = 0; t < 40 && !frame_valid; t++) @(negedge aclk);
        chk({nm, "_latency"}, cyc - n, 11);
        chk({nm, "_number"}, frame_number, en);
        chk({nm, "_count"}, frame_count, ec);
        chk({nm, "_number_h4"}, frame_number2, en4);
        chk({nm, "_count_h4"}, frame_count2, ec4);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int p0;
        logic [3:0] pat;
        // reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tnumber", m_tnumber, 0);
        chk("rst_tcount", m_tcount, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tuser", m_tuser, 0);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_frame_number", frame_number, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_s_tready", s_tready, 1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        run = 1;
        idle(5);

        // first beat also opens the first frame: empty-histogram vote
        send(mk(3, 7, 5, 3), 1'b1, 1'b0);
        wait_out("basic", 3, 7);
        wait_fv("first_frame", 0, 0, 0, 0);

        // tie goes low; reject threshold
        param_min_count = 4'd4;
        send(mk(2, 4, 6, 4), 1'b0, 1'b0);
        wait_out("tie", 2, 4);
        param_min_count = 4'd5;
        send(mk(2, 4, 6, 4), 1'b0, 1'b1);
        wait_out("reject", 10, 4);
        idle(3);

        // backpressure with gaps
        param_min_count = 4'd0;
        pat = 4'b1001;
        bp_on = 1;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    send(mk(i % NC, 1 + i % 7, (i + 3) % NC, i % 4), 1'b0, (i % 4) == 3);
                    idle($urandom_range(0, 2));
                end
                bp_on = 0;
            end
            begin
                for (int k = 0; bp_on; k++) begin
                    m_tready = pat[3 - (k % 4)];
                    @(posedge aclk);
                    #1;
                end
            end
        join
        m_tready = 1'b1;
        idle(10);
        chk("bp_drained", pq.size(), 0);

        // frame vote: 60 x class 7, 39 x class 1, 1 rejected
        param_min_count = 4'd1;
        send(mk(7, 5, 0, 0), 1'b1, 1'b0);
        for (int i = 0; i < 59; i++) send(mk(7, 5, 2, 2), 1'b0, 1'b0);
        for (int i = 0; i < 39; i++) send(mk(1, 6, 0, 0), 1'b0, 1'b0);
        send('0, 1'b0, 1'b1);
        send(mk(2, 3, 0, 0), 1'b1, 1'b0);
        wait_frame("vote", 7, 60, 1, 15);
        idle(20);

        // short frame: first scan is abandoned
        p0 = fv_pulses;
        send(mk(4, 4, 0, 0), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send(mk(4, 4, 0, 0), 1'b0, 1'b0);
        send(mk(4, 4, 0, 0), 1'b1, 1'b0);
        idle(25);
        chk("short_pulses", fv_pulses - p0, 1);
        chk("short_number", frame_number, 4);
        chk("short_count", frame_count, 4);

        // saturation of the narrow histogram
        param_min_count = 4'd0;
        send(mk(0, 3, 0, 0), 1'b1, 1'b0);
        for (int i = 0; i < 19; i++) send(mk(0, 3, 0, 0), 1'b0, 1'b0);
        send(mk(0, 3, 0, 0), 1'b1, 1'b0);
        wait_frame("sat", 0, 20, 0, 15);
        idle(20);

        chk("model_drained", pq.size(), 0);
        chk("frames_drained", fq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
